plot_column_scheduler: RTL and testbench

// Sequences the stack_machine expression evaluator across every screen column: for x = 0 .. HOR_ACTIVE_PIXELS-1

---
 rtl/plot_column_scheduler_if.sv | 29 ++
 rtl/plot_column_scheduler.sv | 119 +++++++++++
 tb/tb_plot_column_scheduler.sv | 293 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/plot_column_scheduler_if.sv
// Bundles the plot control, stack_machine handshake and column RAM write signals
// that the column scheduler drives or consumes.
interface plot_column_scheduler_if #(
   parameter int NUMBER_WIDTH = 16,
   parameter int ADDR_W       = 10,
   parameter int DATA_W       = 10
);
   logic                    plot_start;
   logic                    plot_busy;
   logic                    plot_done;
   logic                    plot_error;
   logic                    sm_start;
   logic                    sm_ready;
   logic [NUMBER_WIDTH-1:0] sm_x;
   logic [NUMBER_WIDTH-1:0] sm_y;
   logic                    col_we;
   logic [ADDR_W-1:0]       col_addr;
   logic [DATA_W-1:0]       col_data;

   modport master (
      input  plot_start, sm_ready, sm_y,
      output plot_busy, plot_done, plot_error, sm_start, sm_x, col_we, col_addr, col_data
   );

   modport slave (
      output plot_start, sm_ready, sm_y,
      input  plot_busy, plot_done, plot_error, sm_start, sm_x, col_we, col_addr, col_data
   );
endinterface

// File: rtl/plot_column_scheduler.sv
// Walks x across every screen column, runs one stack_machine evaluation per column
// and writes the range-checked {valid, y} result into the column buffer.
module plot_column_scheduler #(
   parameter int HOR_ACTIVE_PIXELS = 640,
   parameter int VER_ACTIVE_PIXELS = 480,
   parameter int NUMBER_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES    = 4096
) (
   input logic                    clk,
   input logic                    rst,
   plot_column_scheduler_if.master bus
);
   localparam int ADDR_W = $clog2(HOR_ACTIVE_PIXELS);
   localparam int Y_W    = $clog2(VER_ACTIVE_PIXELS);
   localparam int CNT_W  = $clog2(TIMEOUT_CYCLES);
   localparam logic [ADDR_W-1:0]       LAST_X  = ADDR_W'(HOR_ACTIVE_PIXELS - 1);
   localparam logic [CNT_W-1:0]        CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [NUMBER_WIDTH-1:0] Y_LIMIT = NUMBER_WIDTH'(VER_ACTIVE_PIXELS);

   typedef enum logic [2:0] {
      S_IDLE, S_ISSUE, S_WAIT_ACK, S_WAIT_DONE, S_WRITE, S_NEXT
   } state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] x_q;
   logic [CNT_W-1:0]  cnt_q;
   logic              restart_pend_q;
   logic              busy_q;
   logic              done_q;
   logic              error_q;
   logic              sm_start_q;
   logic              col_we_q;
   logic [Y_W:0]      col_data_q;

   logic              y_valid_d;
   logic [Y_W:0]      col_data_d;

   // Non-negative (MSB clear) makes the unsigned compare equal to the signed one.
   assign y_valid_d  = !bus.sm_y[NUMBER_WIDTH-1] && (bus.sm_y < Y_LIMIT);
   assign col_data_d = y_valid_d ? {1'b1, bus.sm_y[Y_W-1:0]} : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         x_q            <= '0;
         cnt_q          <= '0;
         restart_pend_q <= 1'b0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         sm_start_q     <= 1'b0;
         col_we_q       <= 1'b0;
         col_data_q     <= '0;
      end else begin
         sm_start_q <= 1'b0;
         col_we_q   <= 1'b0;
         done_q     <= 1'b0;
         // The evaluator cannot be aborted, so a start while busy is deferred to NEXT.
         if (bus.plot_start && state_q != S_IDLE) restart_pend_q <= 1'b1;
         case (state_q)
            S_IDLE: begin
               if (bus.plot_start) begin
                  x_q        <= '0;
                  busy_q     <= 1'b1;
                  error_q    <= 1'b0;
                  sm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               cnt_q   <= '0;
               state_q <= S_WAIT_ACK;
            end
            S_WAIT_ACK: state_q <= S_WAIT_DONE;
            S_WAIT_DONE: begin
               if (bus.sm_ready) begin
                  col_we_q   <= !(restart_pend_q || bus.plot_start);
                  col_data_q <= col_data_d;
                  state_q    <= S_WRITE;
               end else if (cnt_q == CNT_MAX) begin
                  error_q        <= 1'b1;
                  busy_q         <= 1'b0;
                  restart_pend_q <= 1'b0;
                  state_q        <= S_IDLE;
               end else begin
                  cnt_q <= cnt_q + CNT_W'(1);
               end
            end
            S_WRITE: state_q <= S_NEXT;
            S_NEXT: begin
               if (restart_pend_q || bus.plot_start) begin
                  x_q            <= '0;
                  restart_pend_q <= 1'b0;
                  sm_start_q     <= 1'b1;
                  state_q        <= S_ISSUE;
               end else if (x_q == LAST_X) begin
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  x_q        <= x_q + ADDR_W'(1);
                  sm_start_q <= 1'b1;
                  state_q    <= S_ISSUE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.plot_busy  = busy_q;
   assign bus.plot_done  = done_q;
   assign bus.plot_error = error_q;
   assign bus.sm_start   = sm_start_q;
   assign bus.sm_x       = NUMBER_WIDTH'(x_q);
   assign bus.col_we     = col_we_q;
   assign bus.col_addr   = x_q;
   assign bus.col_data   = col_data_q;
endmodule

// File: tb/tb_plot_column_scheduler.sv
// Drives plot passes against a modelled stack_machine and scores every column write
// against the expected {valid, y} sequence.
module tb_plot_column_scheduler;
   localparam int H  = 640;
   localparam int V  = 480;
   localparam int NW = 16;
   localparam int TO = 4096;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   plot_column_scheduler_if #(.NUMBER_WIDTH(NW), .ADDR_W(10), .DATA_W(10)) bus ();

   plot_column_scheduler #(
      .HOR_ACTIVE_PIXELS(H), .VER_ACTIVE_PIXELS(V),
      .NUMBER_WIDTH(NW), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .bus(bus)
   );

   int          checks = 0;
   int          errors = 0;
   logic [15:0] yval [H];
   int          lat_fix = 10;
   int          hang_col = -1;
   int          exp_addr [$];
   int          exp_data [$];
   int          done_cnt = 0;
   int          last_addr = -1;
   logic        prev_start = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Expected column word: valid iff 0 <= y < V as a signed number.
   function automatic int ref_data(input logic [15:0] y);
      int yi;
      yi = $signed(y);
      if (yi >= 0 && yi < V) return 512 + yi;
      return 0;
   endfunction

   task automatic load_pass();
      exp_addr.delete();
      exp_data.delete();
      for (int x = 0; x < H; x++) begin
         exp_addr.push_back(x);
         exp_data.push_back(ref_data(yval[x]));
      end
   endtask

   task automatic fill_linear();
      for (int x = 0; x < H; x++) yval[x] = 16'(x - 320);
   endtask

   task automatic fill_random();
      for (int x = 0; x < H; x++)
         yval[x] = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 600)) - 60);
      yval[0] = 16'hFFFF;
      yval[1] = 16'd479;
      yval[2] = 16'd480;
      yval[3] = 16'h7FFF;
   endtask

   task automatic pulse_start();
      bus.plot_start = 1'b1;
      @(negedge clk);
      bus.plot_start = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int n = 0;
      while (bus.plot_done !== 1'b1 && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.plot_done, 1);
   endtask

   task automatic wait_issue(input int xv, input string tag);
      int n = 0;
      while (!(bus.sm_start === 1'b1 && bus.sm_x == 16'(xv)) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.sm_start, 1);
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (bus.sm_ready !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk(tag, bus.sm_ready, 1);
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_busy"}, bus.plot_busy, 0);
      chk({tag, "_done"}, bus.plot_done, 0);
      chk({tag, "_error"}, bus.plot_error, 0);
      chk({tag, "_sm_start"}, bus.sm_start, 0);
      chk({tag, "_col_we"}, bus.col_we, 0);
      chk({tag, "_sm_x"}, bus.sm_x, 0);
      chk({tag, "_col_addr"}, bus.col_addr, 0);
      chk({tag, "_col_data"}, bus.col_data, 0);
   endtask

   // Stack_machine model: ready drops one cycle after start, rises after a latency with y(x).
   initial begin
      int xc;
      int lat;
      bus.sm_ready = 1'b1;
      bus.sm_y     = '0;
      forever begin
         @(negedge clk);
         if (bus.sm_start === 1'b1) begin
            xc = int'(bus.sm_x);
            @(negedge clk);
            bus.sm_ready = 1'b0;
            bus.sm_y     = 16'($urandom);
            lat = (lat_fix > 0) ? lat_fix : int'($urandom_range(1, 8));
            repeat (lat) @(negedge clk);
            while (hang_col == xc) @(negedge clk);
            if (bus.plot_busy === 1'b1) chk("sm_x_stable", bus.sm_x, xc);
            bus.sm_y     = yval[xc];
            bus.sm_ready = 1'b1;
         end
      end
   end

   // Write scoreboard and start-pulse width monitor.
   initial begin
      int ea;
      int ed;
      forever begin
         @(posedge clk);
         #1;
         if (rst) begin
            prev_start = 1'b0;
         end else begin
            if (bus.sm_start === 1'b1) chk("sm_start_pulse", prev_start, 0);
            prev_start = bus.sm_start;
            if (bus.col_we === 1'b1) begin
               if (exp_addr.size() == 0) begin
                  chk("unexpected_write", bus.col_addr, 32'hFFFF);
               end else begin
                  ea = exp_addr.pop_front();
                  ed = exp_data.pop_front();
                  chk("col_addr", bus.col_addr, ea);
                  chk("col_data", bus.col_data, ed);
                  chk("busy_on_write", bus.plot_busy, 1);
                  last_addr = int'(bus.col_addr);
               end
            end
            if (bus.plot_done === 1'b1) done_cnt++;
         end
      end
   end

   initial begin
      int n;
      bus.plot_start = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check_idle("reset");
      rst = 1'b0;
      @(negedge clk);

      // Pass A: y = x-320, fixed 10-cycle evaluator.
      fill_linear();
      lat_fix = 10;
      load_pass();
      done_cnt = 0;
      pulse_start();
      chk("a_busy_after_start", bus.plot_busy, 1);
      chk("a_first_x", bus.sm_x, 0);
      wait_done("a_done");
      chk("a_busy_at_done", bus.plot_busy, 0);
      chk("a_error", bus.plot_error, 0);
      chk("a_remaining", exp_addr.size(), 0);
      chk("a_last_addr", last_addr, H - 1);
      @(negedge clk);
      chk("a_done_width", bus.plot_done, 0);
      chk("a_done_count", done_cnt, 1);
      $display("pass A linear: %0d writes scored", H);

      // Pass B random y with boundary values, restarted in its final NEXT cycle.
      fill_random();
      lat_fix = 0;
      load_pass();
      done_cnt = 0;
      pulse_start();
      n = 0;
      while (!(bus.col_we === 1'b1 && bus.col_addr == 10'(H - 1)) && n < 20000) begin
         @(negedge clk);
         n++;
      end
      chk("b_last_write_seen", bus.col_we, 1);
      @(negedge clk);
      chk("b_remaining", exp_addr.size(), 0);
      bus.plot_start = 1'b1;
      load_pass();
      @(negedge clk);
      bus.plot_start = 1'b0;
      chk("c_busy_kept", bus.plot_busy, 1);
      chk("c_restart_x", bus.sm_x, 0);
      wait_done("c_done");
      chk("c_done_count", done_cnt, 1);
      chk("c_remaining", exp_addr.size(), 0);
      $display("pass B/C random with restart at last column: done pulses %0d", done_cnt);

      // Restart requested while column 100 is being evaluated.
      fill_random();
      load_pass();
      done_cnt = 0;
      pulse_start();
      wait_issue(100, "r_issue_100");
      chk("r_written_before", exp_addr.size(), H - 100);
      bus.plot_start = 1'b1;
      load_pass();
      repeat (2) @(negedge clk);
      bus.plot_start = 1'b0;
      chk("r_busy", bus.plot_busy, 1);
      wait_done("r_done");
      chk("r_done_count", done_cnt, 1);
      chk("r_remaining", exp_addr.size(), 0);
      chk("r_error", bus.plot_error, 0);
      $display("restart at column 100: full pass rescored");

      // Evaluator never answers column 5.
      fill_linear();
      lat_fix = 3;
      hang_col = 5;
      load_pass();
      while (exp_addr.size() > 5) begin
         void'(exp_addr.pop_back());
         void'(exp_data.pop_back());
      end
      pulse_start();
      wait_issue(5, "t_issue_5");
      n = 0;
      while (bus.plot_error !== 1'b1 && n < 5000) begin
         @(negedge clk);
         n++;
      end
      chk("t_error", bus.plot_error, 1);
      chk("t_cycles", n, TO + 2);
      chk("t_busy", bus.plot_busy, 0);
      chk("t_remaining", exp_addr.size(), 0);
      chk("t_last_addr", last_addr, 4);
      hang_col = -1;
      wait_ready("t_ready_back");
      repeat (2) @(negedge clk);
      chk("t_error_sticky", bus.plot_error, 1);
      $display("timeout at column 5 after %0d cycles", n);

      // Reset in the middle of a pass, then a clean pass from address 0.
      lat_fix = 0;
      load_pass();
      pulse_start();
      chk("s_error_cleared", bus.plot_error, 0);
      wait_issue(300, "s_issue_300");
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check_idle("midreset");
      exp_addr.delete();
      exp_data.delete();
      wait_ready("s_ready_back");
      @(negedge clk);
      load_pass();
      done_cnt = 0;
      pulse_start();
      chk("s_restart_x", bus.sm_x, 0);
      chk("s_busy", bus.plot_busy, 1);
      wait_done("s_done");
      chk("s_done_count", done_cnt, 1);
      chk("s_remaining", exp_addr.size(), 0);
      $display("reset at column 300 then full pass");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
